// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x oversampling UART receiver, 8 data bits LSB first, with a
// first-word-fall-through RX FIFO behind a valid/ready read port.
// Optional feature macro: UART_RX_PARITY_EN. When it is defined, a parity bit sits
// between the data bits and the stop bit. When it is undefined, the frame is 8N1.

module uart_rx_core #(
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             par_odd_i,
    input  logic             cio_rx_i,
    output logic [7:0]       rx_data_o,
    output logic             rx_valid_o,
    input  logic             rx_ready_i,
    output logic             frame_err_o,
    output logic             parity_err_o,
    output logic             overflow_o,
    output logic             busy_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0]    DEPTH_P = PW'(FIFO_DEPTH);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    // Majority of the three mid-bit samples.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

`ifdef UART_RX_PARITY_EN
    // Expected parity bit: even parity makes the total count of ones even.
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;
`endif

    state_t           state_r;
    state_t           state_next_s;
    logic             rx_meta_r;
    logic             rx_sync_r;
    logic             rx_prev_r;
    logic [DIV_W-1:0] tick_cnt_r;
    logic [3:0]       samp_cnt_r;
    logic             samp7_r;
    logic             samp8_r;
    logic [2:0]       bit_cnt_r;
    logic [7:0]       shift_r;
    logic             fall_s;
    logic             start_s;
    logic             tick_s;
    logic             decide_s;
    logic             bit_s;
    logic             shift_en_s;
    logic             push_s;
    logic             frame_err_s;

`ifdef UART_RX_PARITY_EN
    logic             par_odd_r;
    logic             par_flag_r;
    logic             par_capture_s;
    logic             par_check_s;
    logic             parity_err_s;
`else
    logic             par_odd_unused_s;
    assign par_odd_unused_s = par_odd_i;
`endif

    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    wr_ptr_next_s;
    logic [PW-1:0]    rd_ptr_next_s;
    logic             pop_s;
    logic             full_s;
    logic             push_ok_s;
    logic [7:0]       head_next_s;

    assign fall_s   = rx_prev_r & ~rx_sync_r;
    assign start_s  = enable_i & (state_r == ST_IDLE) & fall_s;
    assign tick_s   = (state_r != ST_IDLE) && (tick_cnt_r == {DIV_W{1'b0}});
    assign decide_s = tick_s && (samp_cnt_r == 4'd9);
    assign bit_s    = majority3(samp7_r, samp8_r, rx_sync_r);

    // Two-flop line synchronizer plus a delayed copy for 1->0 edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= cio_rx_i;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Oversample divider: reloads from div_i at frame start and on every tick.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tick_cnt_r <= {DIV_W{1'b0}};
        end else if (start_s || tick_s) begin
            tick_cnt_r <= div_i;
        end else if (state_r != ST_IDLE) begin
            tick_cnt_r <= tick_cnt_r - DIV_ONE;
        end
    end

    // Position within the current bit (0..15, wraps into the next bit).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            samp_cnt_r <= 4'd0;
        end else if (start_s) begin
            samp_cnt_r <= 4'd0;
        end else if (tick_s) begin
            samp_cnt_r <= samp_cnt_r + 4'd1;
        end
    end

    // Capture the first two of the three mid-bit samples; the third is live.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            samp7_r <= 1'b1;
            samp8_r <= 1'b1;
        end else if (tick_s && (samp_cnt_r == 4'd7)) begin
            samp7_r <= rx_sync_r;
        end else if (tick_s && (samp_cnt_r == 4'd8)) begin
            samp8_r <= rx_sync_r;
        end
    end

    // Data shift register (LSB arrives first, so shift in at the MSB) and bit count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'd0;
        end else if (start_s) begin
            bit_cnt_r <= 3'd0;
        end else if (shift_en_s) begin
            bit_cnt_r <= bit_cnt_r + 3'd1;
            shift_r   <= {bit_s, shift_r[7:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity mode latched when data starts; mismatch flag held until the stop bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            par_odd_r  <= 1'b0;
            par_flag_r <= 1'b0;
        end else if (start_s) begin
            par_flag_r <= 1'b0;
        end else begin
            if (par_capture_s) begin
                par_odd_r <= par_odd_i;
            end
            if (par_check_s) begin
                par_flag_r <= (bit_s != parity_bit(shift_r, par_odd_r));
            end
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state and per-cycle control strobes.
    always_comb begin
        state_next_s  = state_r;
        shift_en_s    = 1'b0;
        push_s        = 1'b0;
        frame_err_s   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_capture_s = 1'b0;
        par_check_s   = 1'b0;
        parity_err_s  = 1'b0;
`endif
        if (!enable_i) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (fall_s) begin
                        state_next_s = ST_START;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (decide_s && !bit_s) begin
                        state_next_s = ST_DATA;
`ifdef UART_RX_PARITY_EN
                        par_capture_s = 1'b1;
`endif
                    end else if (decide_s) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_START;
                    end
                end
                ST_DATA: begin
                    if (decide_s) begin
                        shift_en_s = 1'b1;
                        if (bit_cnt_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_next_s = ST_PARITY;
`else
                            state_next_s = ST_STOP;
`endif
                        end else begin
                            state_next_s = ST_DATA;
                        end
                    end else begin
                        state_next_s = ST_DATA;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (decide_s) begin
                        par_check_s  = 1'b1;
                        state_next_s = ST_STOP;
                    end else begin
                        state_next_s = ST_PARITY;
                    end
                end
                ST_STOP: begin
                    if (decide_s && bit_s && !par_flag_r) begin
                        push_s       = 1'b1;
                        state_next_s = ST_IDLE;
                    end else if (decide_s && !bit_s) begin
                        frame_err_s  = 1'b1;
                        state_next_s = ST_BREAK;
                    end else if (decide_s) begin
                        parity_err_s = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_STOP;
                    end
                end
`else
                ST_STOP: begin
                    if (decide_s && bit_s) begin
                        push_s       = 1'b1;
                        state_next_s = ST_IDLE;
                    end else if (decide_s) begin
                        frame_err_s  = 1'b1;
                        state_next_s = ST_BREAK;
                    end else begin
                        state_next_s = ST_STOP;
                    end
                end
`endif
                ST_BREAK: begin
                    if (rx_sync_r) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_BREAK;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    assign pop_s         = rx_valid_o & rx_ready_i;
    assign full_s        = ((wr_ptr_r - rd_ptr_r) == DEPTH_P);
    assign push_ok_s     = push_s & (~full_s | pop_s);
    assign wr_ptr_next_s = wr_ptr_r + {{AW{1'b0}}, push_ok_s};
    assign rd_ptr_next_s = rd_ptr_r + {{AW{1'b0}}, pop_s};

    // Next head byte; a byte landing in an otherwise empty slot bypasses the array.
    always_comb begin
        head_next_s = mem_r[rd_ptr_next_s[AW-1:0]];
        if (push_ok_s && (wr_ptr_r[AW-1:0] == rd_ptr_next_s[AW-1:0])) begin
            head_next_s = shift_r;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s[AW-1:0]];
        end
    end

    // FIFO storage, pointers and registered read port.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'd0;
            end
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            rx_data_o  <= 8'd0;
            rx_valid_o <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= shift_r;
            end
            wr_ptr_r   <= wr_ptr_next_s;
            rd_ptr_r   <= rd_ptr_next_s;
            rx_data_o  <= head_next_s;
            rx_valid_o <= (wr_ptr_next_s != rd_ptr_next_s);
        end
    end

    // Registered status outputs; busy_o mirrors the state register exactly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_err_o  <= 1'b0;
            parity_err_o <= 1'b0;
            overflow_o   <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            frame_err_o  <= frame_err_s;
`ifdef UART_RX_PARITY_EN
            parity_err_o <= parity_err_s;
`else
            parity_err_o <= 1'b0;
`endif
            overflow_o   <= push_s & full_s & ~pop_s;
            busy_o       <= (state_next_s != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: stimulus pushes expected bytes/events into
// scoreboard queues; an independent monitor pops and compares on DUT outputs.
module tb_uart_rx_core;
    localparam int DIV_W    = 16;
    localparam int DEPTH    = 4;
    localparam int EV_FRAME = 1;
    localparam int EV_PAR   = 2;
    localparam int EV_OVF   = 3;
`ifdef UART_RX_PARITY_EN
    localparam int LAT_LO   = 664;
    localparam int LAT_HI   = 704;
`else
    localparam int LAT_LO   = 600;
    localparam int LAT_HI   = 640;
`endif

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             enable_i = 1'b1;
    logic [DIV_W-1:0] div_i = '0;
    logic             par_odd_i = 1'b0;
    logic             cio_rx_i = 1'b1;
    logic [7:0]       rx_data_o;
    logic             rx_valid_o;
    logic             rx_ready_i = 1'b1;
    logic             frame_err_o;
    logic             parity_err_o;
    logic             overflow_o;
    logic             busy_o;

    logic [7:0] exp_bytes[$];
    int         exp_events[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         bit_clks = 64;
`ifdef UART_RX_PARITY_EN
    bit         par_flip = 1'b0;
`endif

    always #5 clk = ~clk;

    uart_rx_core #(.DIV_W(DIV_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .div_i(div_i),
        .par_odd_i(par_odd_i), .cio_rx_i(cio_rx_i), .rx_data_o(rx_data_o),
        .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .frame_err_o(frame_err_o),
        .parity_err_o(parity_err_o), .overflow_o(overflow_o), .busy_o(busy_o)
    );

    function automatic void check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void unexpected(input string name, input int act);
        vectors++;
        miscompares++;
        $display("FAIL %s: unexpected output 0x%0h with nothing expected", name, act);
    endfunction

    function automatic void take_event(input string name, input int kind);
        if (exp_events.size() == 0) unexpected(name, kind);
        else check(name, kind, exp_events.pop_front());
    endfunction

    // Monitor: compares every handshake and every status pulse against the scoreboard.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (rx_valid_o && rx_ready_i) begin
                if (exp_bytes.size() == 0) unexpected("extra_byte", rx_data_o);
                else check("rx_byte", rx_data_o, exp_bytes.pop_front());
            end
            if (frame_err_o)  take_event("frame_err", EV_FRAME);
            if (parity_err_o) take_event("parity_err", EV_PAR);
            if (overflow_o)   take_event("overflow", EV_OVF);
        end
    end

    // Watchdog so the run always ends.
    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: run exceeded cycle budget");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_div(input int d);
        div_i    = DIV_W'(d);
        bit_clks = 16 * (d + 1);
    endtask

    // Reference model: what one frame must produce, from the frame rules alone.
    function automatic void predict(input logic [7:0] d, input bit stop);
        if (!stop) exp_events.push_back(EV_FRAME);
`ifdef UART_RX_PARITY_EN
        else if (par_flip) exp_events.push_back(EV_PAR);
`endif
        else if (!rx_ready_i && exp_bytes.size() >= DEPTH) exp_events.push_back(EV_OVF);
        else exp_bytes.push_back(d);
    endfunction

    task automatic send_frame(input logic [7:0] d, input bit stop, input int brk_bits);
        predict(d, stop);
        cio_rx_i = 1'b0;
        step(bit_clks);
        for (int i = 0; i < 8; i++) begin
            cio_rx_i = d[i];
            step(bit_clks);
        end
`ifdef UART_RX_PARITY_EN
        cio_rx_i = (^d) ^ par_odd_i ^ par_flip;
        step(bit_clks);
`endif
        cio_rx_i = stop;
        step(bit_clks);
        if (!stop) begin
            step(brk_bits * bit_clks);
            cio_rx_i = 1'b1;
            step(bit_clks);
        end
    endtask

    task automatic send_partial(input logic [7:0] d, input int nbits, input int extra);
        cio_rx_i = 1'b0;
        step(bit_clks);
        for (int i = 0; i < nbits; i++) begin
            cio_rx_i = d[i];
            step(bit_clks);
        end
        cio_rx_i = d[nbits];
        step(extra);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, rx_valid_o, 0);
        check({tag, "_data"}, rx_data_o, 0);
        check({tag, "_frame_err"}, frame_err_o, 0);
        check({tag, "_parity_err"}, parity_err_o, 0);
        check({tag, "_overflow"}, overflow_o, 0);
        check({tag, "_busy"}, busy_o, 0);
    endtask

    task automatic drain(input string tag);
        step(2 * bit_clks);
        check({tag, "_bytes_pending"}, exp_bytes.size(), 0);
        check({tag, "_events_pending"}, exp_events.size(), 0);
    endtask

    initial begin
        int lat;
        logic [7:0] d;
        set_div(3);
        step(5);
        rst_i = 1'b0;
        step(2);
        check_idle_outputs("reset");

        // Single 0xA5 frame with start-to-valid latency measurement.
        fork
            send_frame(8'hA5, 1'b1, 0);
            begin
                lat = 0;
                while (!rx_valid_o && lat < 2000) begin
                    step(1);
                    lat++;
                end
            end
        join
        vectors++;
        if (lat < LAT_LO || lat > LAT_HI) begin
            miscompares++;
            $display("FAIL latency: got %0d clocks, expected %0d..%0d", lat, LAT_LO, LAT_HI);
        end
        drain("a5");

        // Start-bit glitch: 20 clocks low must be rejected silently.
        cio_rx_i = 1'b0;
        step(6);
        check("glitch_busy_high", busy_o, 1);
        step(14);
        cio_rx_i = 1'b1;
        step(60);
        check("glitch_busy_low", busy_o, 0);

        // Framing error with a held break, then a good frame.
        send_frame(8'h3C, 1'b0, 3);
        send_frame(8'h11, 1'b1, 0);
        drain("break");

        // Overflow: five frames into a four-entry FIFO with no reader.
        rx_ready_i = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 0);
        step(bit_clks);
        check("full_valid", rx_valid_o, 1);
        check("full_head", rx_data_o, 8'h01);
        rx_ready_i = 1'b1;
        step(12);
        check("drained_valid", rx_valid_o, 0);
        drain("overflow");

        // Reset in the middle of data bit 4.
        send_partial(8'h77, 4, bit_clks / 2);
        cio_rx_i = 1'b1;
        rst_i = 1'b1;
        step(1);
        rst_i = 1'b0;
        check_idle_outputs("midreset");
        step(bit_clks);
        send_frame(8'h5A, 1'b1, 0);
        drain("after_reset");

        // Enable dropped mid-frame: frame discarded, receiver usable afterwards.
        send_partial(8'h0F, 2, 5);
        enable_i = 1'b0;
        step(3);
        check("disable_busy", busy_o, 0);
        cio_rx_i = 1'b1;
        step(bit_clks);
        enable_i = 1'b1;
        step(bit_clks);
        send_frame(8'h33, 1'b1, 0);
        drain("enable");

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 with a wrong then a correct parity bit.
        par_odd_i = 1'b0;
        par_flip  = 1'b1;
        send_frame(8'h07, 1'b1, 0);
        par_flip  = 1'b0;
        send_frame(8'h07, 1'b1, 0);
        drain("parity");
`endif

        // Randomized frames: data, divider, stop errors and inter-frame gaps.
        for (int n = 0; n < 24; n++) begin
            d = 8'($urandom_range(0, 255));
            set_div($urandom_range(0, 3));
            par_odd_i = 1'($urandom_range(0, 1));
`ifdef UART_RX_PARITY_EN
            par_flip = ($urandom_range(0, 5) == 0);
`endif
            send_frame(d, ($urandom_range(0, 7) != 0), 1);
            if ($urandom_range(0, 1) == 1) step($urandom_range(1, bit_clks));
        end
        set_div(3);
        drain("random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
